// File: rtl/pmem_pkg.sv
// rtl/pmem_pkg.sv - shared constants and types for the pmem burst responder
package pmem_pkg;

  localparam int BURST_LEN        = 4;
  localparam int BEAT_W           = 64;
  localparam int LINE_OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } pmem_state_t;

  typedef logic [BEAT_W-1:0] pmem_beat_t;

endpackage

// File: rtl/pmem_storage.sv
// rtl/pmem_storage.sv - single-port beat RAM, synchronous registered read, write-first
module pmem_storage
  import pmem_pkg::*;
#(
  parameter int DEPTH = 4096,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  pmem_beat_t    wdata_i,
  output pmem_beat_t    rdata_o
);

  pmem_beat_t mem_q [DEPTH];
  pmem_beat_t rdata_q;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= we_i ? wdata_i : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pmem_burst_responder.sv
// rtl/pmem_burst_responder.sv - mp4 pmem slave: 4-beat line bursts after a fixed latency
module pmem_burst_responder
  import pmem_pkg::*;
#(
  parameter int LINES     = 1024,
  parameter int LATENCY   = 8,
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  logic [63:0] pmem_wdata,
  output logic [63:0] pmem_rdata,
  output logic        pmem_resp,
  output logic        proto_err
);

  localparam int IDX_W   = $clog2(LINES);
  localparam int BEAT_CW = $clog2(BURST_LEN);
  localparam int LAT_W   = $clog2(LATENCY + 1);
  localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BURST_LEN - 1);

  pmem_state_t        state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [BEAT_CW-1:0] beat_q, beat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               op_wr_q, op_wr_d;
  logic               err_q, err_d;

  logic               mem_re;
  logic               mem_we;
  logic [BEAT_CW-1:0] mem_beat;
  logic               viol;
  logic               unused_addr;

  assign unused_addr = &{1'b0, pmem_address};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      op_wr_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      op_wr_q <= op_wr_d;
      err_q   <= err_d;
    end
  end

  // Mid-transaction violations: latched op's request dropped, or the other request raised.
  always_comb begin
    viol = 1'b0;
    if (state_q == IDLE) begin
      viol = pmem_read & pmem_write;
    end else if (state_q == WAIT || state_q == BURST) begin
      viol = op_wr_q ? (!pmem_write || pmem_read) : (!pmem_read || pmem_write);
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    op_wr_d = op_wr_q;
    err_d   = err_q | viol;
    case (state_q)
      IDLE: begin
        if (pmem_read ^ pmem_write) begin
          state_d = WAIT;
          lat_d   = LAT_W'(LATENCY);
          beat_d  = '0;
          idx_d   = pmem_address[IDX_W+LINE_OFFSET_BITS-1:LINE_OFFSET_BITS];
          op_wr_d = pmem_write;
        end
      end
      WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          state_d = BURST;
          beat_d  = '0;
        end
      end
      BURST: begin
        beat_d = beat_q + BEAT_CW'(1);
        if (beat_q == LAST_BEAT) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads run one beat ahead of resp so rdata always leaves the RAM output register.
  always_comb begin
    pmem_resp = (state_q == BURST);
    mem_we    = (state_q == BURST) && op_wr_q && !rst;
    mem_re    = !op_wr_q &&
                (((state_q == WAIT) && (lat_q == LAT_W'(1))) ||
                 ((state_q == BURST) && (beat_q != LAST_BEAT)));
    mem_beat  = '0;
    if (state_q == BURST) begin
      mem_beat = op_wr_q ? beat_q : beat_q + BEAT_CW'(1);
    end
  end

  assign proto_err = err_q;

  pmem_storage #(
    .DEPTH(LINES * BURST_LEN)
  ) u_storage (
    .clk_i  (clk),
    .rst_i  (rst),
    .re_i   (mem_re),
    .we_i   (mem_we),
    .addr_i ({idx_q, mem_beat}),
    .wdata_i(pmem_wdata),
    .rdata_o(pmem_rdata)
  );

endmodule

// File: tb/tb_pmem_burst_responder.sv
// tb/tb_pmem_burst_responder.sv - scoreboard bench for the pmem burst responder
module tb_pmem_burst_responder;

  localparam int LATENCY = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pmem_read = 1'b0;
  logic        pmem_write = 1'b0;
  logic [31:0] pmem_address = '0;
  logic [63:0] pmem_wdata = '0;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;
  logic        proto_err;

  always #5 clk = ~clk;

  pmem_burst_responder #(
    .LINES(1024),
    .LATENCY(LATENCY),
    .BURST_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp),
    .proto_err(proto_err)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [63:0] exp_q[$];
  bit          mon_read = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pmem_resp && mon_read) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL extra_beat: got resp with rdata %h expected no beat", pmem_rdata);
      end else begin
        chk("rdata", pmem_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic txn(input bit wr, input logic [31:0] addr, input logic [3:0][63:0] d,
                     input bit hold, input int rst_beat,
                     output int first_edge, output int last_edge);
    int a;
    int w;
    int nb;
    first_edge = 0;
    last_edge  = 0;
    @(negedge clk);
    mon_read = !wr;
    if (!wr) for (int b = 0; b < 4; b++) exp_q.push_back(d[b]);
    pmem_address = addr;
    pmem_read    = !wr;
    pmem_write   = wr;
    pmem_wdata   = d[0];
    a = cyc + 1;
    w = 0;
    @(negedge clk);
    while (!pmem_resp && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!pmem_resp) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got no resp within 100 cycles expected a burst at addr %h", addr);
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      return;
    end
    first_edge = cyc + 1;
    chk("first_beat_latency", 64'(first_edge - a), 64'(LATENCY + 1));
    nb = 0;
    for (int b = 0; b < 4; b++) begin
      if (!pmem_resp) break;
      pmem_wdata = d[b];
      nb++;
      last_edge = cyc + 1;
      if (b == rst_beat) rst = 1'b1;
      @(negedge clk);
      if (rst) break;
    end
    chk("resp_after_burst", 64'(pmem_resp), 64'(0));
    chk("beat_count", 64'(nb), 64'((rst_beat < 0) ? 4 : rst_beat + 1));
    rst = 1'b0;
    if (!hold) begin
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected end of run");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0][63:0] la, lb, lc, ld, le, mix;
    int f1, l1, f2, l2, cnt;
    la  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    lb  = {64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002,
           64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000};
    lc  = {64'hC3C3_C3C3_0000_FFFF, 64'hC2C2_C2C2_0000_FFFF,
           64'hC1C1_C1C1_0000_FFFF, 64'hC0C0_C0C0_0000_FFFF};
    ld  = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
           64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
    le  = {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2,
           64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};
    mix = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
           64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};

    repeat (3) @(negedge clk);
    chk("reset_resp", 64'(pmem_resp), 64'(0));
    chk("reset_rdata", pmem_rdata, 64'(0));
    chk("reset_proto_err", 64'(proto_err), 64'(0));
    rst = 1'b0;

    // preload, read back, ignored offset bits
    txn(1'b1, 32'h0000_0100, la, 1'b0, -1, f1, l1);
    txn(1'b0, 32'h0000_0100, la, 1'b0, -1, f1, l1);
    txn(1'b0, 32'h0000_010F, la, 1'b0, -1, f1, l1);

    // write a line between two known neighbours
    txn(1'b1, 32'h0000_0280, lb, 1'b0, -1, f1, l1);
    txn(1'b1, 32'h0000_02C0, lc, 1'b0, -1, f1, l1);
    txn(1'b1, 32'h0000_02A0, ld, 1'b0, -1, f1, l1);
    txn(1'b0, 32'h0000_02A0, ld, 1'b0, -1, f1, l1);
    txn(1'b0, 32'h0000_0280, lb, 1'b0, -1, f1, l1);
    txn(1'b0, 32'h0000_02C0, lc, 1'b0, -1, f1, l1);
    chk("proto_err_clean", 64'(proto_err), 64'(0));

    // read and write together in IDLE
    @(negedge clk);
    pmem_address = 32'h0000_0100;
    pmem_read    = 1'b1;
    pmem_write   = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (pmem_resp) cnt++;
    end
    chk("both_high_resp_count", 64'(cnt), 64'(0));
    chk("both_high_proto_err", 64'(proto_err), 64'(1));
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    repeat (5) @(negedge clk);
    chk("proto_err_sticky", 64'(proto_err), 64'(1));
    txn(1'b0, 32'h0000_0100, la, 1'b0, -1, f1, l1);
    chk("proto_err_sticky_after_read", 64'(proto_err), 64'(1));

    // reset during beat 2 of a write
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("proto_err_cleared", 64'(proto_err), 64'(0));
    txn(1'b1, 32'h0000_02A0, le, 1'b0, 2, f1, l1);
    chk("proto_err_after_rst_write", 64'(proto_err), 64'(0));
    txn(1'b0, 32'h0000_02A0, mix, 1'b0, -1, f1, l1);

    // back-to-back reads with the request held through DONE
    txn(1'b0, 32'h0000_0280, lb, 1'b1, -1, f1, l1);
    txn(1'b0, 32'h0000_0280, lb, 1'b0, -1, f2, l2);
    n_cmp++;
    if (f2 - l1 < LATENCY + 2) begin
      n_err++;
      $display("FAIL b2b_gap: got %0d cycles expected at least %0d", f2 - l1, LATENCY + 2);
    end
    chk("proto_err_b2b", 64'(proto_err), 64'(0));

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
